issue_queue: RTL and testbench
==============================

# issue_queue

Collapsing, age-ordered issue queue between the readreg→issue port register and the execute units. It accepts up to `IN_WIDTH` micro-ops per cycle, holds them until both source operands are loaded, and captures operand values from execute/writeback wakeup channels. Each cycle it issues the oldest fully-ready entry. It drives the `stall` back-pressure that readreg sees as `issue_feedback_pack.stall`.

## Interface
- `DEPTH`, 16: number of entries; must be ≥ `IN_WIDTH`.
- `IN_WIDTH`, 2: ops accepted per cycle; equals `READREG_WIDTH`.
- `WAKE_NUM`, 4: wakeup channels; equals 2×`EXECUTE_UNIT_NUM` (execute and writeback channels concatenated).
- `PHY_W`, 6: physical register id width; equals `PHY_REG_ID_WIDTH`.
- `DATA_W`, 32: operand width; equals `REG_DATA_WIDTH`.
- `PAYLOAD_W`, 64: opaque op payload width (rob_id, op, imm, rd_phy, …).

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: pipeline flush (`commit_feedback_pack.enable & flush`).
- `in_valid[IN_WIDTH]` in 1 each: op present on slot i.
- `in_rs{1,2}_phy[IN_WIDTH]` in `PHY_W`: source physical ids.
- `in_src{1,2}_loaded[IN_WIDTH]` in 1: operand already valid.
- `in_src{1,2}_value[IN_WIDTH]` in `DATA_W`: operand value.
- `in_payload[IN_WIDTH]` in `PAYLOAD_W`: carried unchanged.
- `stall` out 1: queue cannot accept a full group.
- `wake_enable[WAKE_NUM]` in 1; `wake_phy_id[WAKE_NUM]` in `PHY_W`; `wake_value[WAKE_NUM]` in `DATA_W`: result broadcast.
- `out_valid` out 1: oldest ready entry presented.
- `out_ready` in 1: consumer accepts this cycle.
- `out_src1_value`, `out_src2_value` out `DATA_W`; `out_payload` out `PAYLOAD_W`.
- `count` out `$clog2(DEPTH+1)`: occupied entries (debug/perf).

## Operation
- Storage: per entry `valid`, rs1/rs2 phy, loaded flags, values, payload. Index 0 is oldest; valid entries are always contiguous from index 0.
- `stall = (DEPTH - count) < IN_WIDTH`. The check is computed from registered `count` only; a same-cycle issue does not relieve it.
- Enqueue when `!stall && !flush`. Valid slots are appended in slot order, so slot 0 is the older one. Invalid slots create no hole; the valid ones are packed.
- Select: `out_valid` = any entry with `valid & src1_loaded & src2_loaded`; the lowest such index is chosen. Outputs are driven combinationally from that entry's registers. When `out_valid=0`, the outputs are don't-care but must be stable (drive entry 0).
- Issue when `out_valid && out_ready`. At the edge the chosen entry is removed, entries above it shift down by one, and new ops are appended after the shifted tail.
- Wakeup: every held entry with an unloaded source compares against all enabled wake channels. On a match, `loaded` is set and the value is captured at the edge. If several channels match, the lowest channel index wins.
- A source that is already loaded is never overwritten.
- `count_next = count - issued + enqueued`.
- Flush: at the edge all `valid` bits clear and `count` goes to 0. In the flush cycle, enqueue, wakeup and issue are suppressed, and `out_valid` is forced 0.

## Timing
- Reset (async): all `valid`=0, `count`=0, `out_valid`=0, `stall`=0. Entry data is don't-care.
- An op enqueued ready at edge N is issuable in cycle N (visible after edge N). Minimum queue latency is 1 cycle.
- A wakeup in cycle N makes the entry ready after edge N. There is no same-cycle wake-to-issue path.
- Full boundary: `count = DEPTH-IN_WIDTH+1` asserts `stall` even if an issue happens that cycle.
- Enqueue + issue + wakeup can all occur in one cycle.
- If an entry shifts down in the same cycle it is woken, it must keep the woken value.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge.

## Configuration
- `ISSUE_QUEUE_WAKEUP_BYPASS_EN`:
  - Defined: incoming ops also compare their unloaded sources against the current-cycle wake channels, and are written already loaded on a match.
  - Undefined: incoming ops are stored exactly as presented. A wake in the enqueue cycle is missed; the producer is responsible for it (readreg's feedback bypass covers execute/wb).

## Test plan
- Reset, then enqueue 2 ops (both loaded, payloads 0x11, 0x22), `out_ready=1` → issue 0x11 then 0x22 on consecutive cycles; `count` goes 2→1→0.
- Enqueue op A (rs1=5 unloaded) then op B (ready); `out_ready=1` → B issues first. Wake phy 5 = 0xacde1285 → A issues next cycle with `out_src1_value=0xacde1285`.
- Fill to `count=15` with unready ops → `stall=1`. Present `in_valid`=11 → nothing enqueued and `count` stays 15.
- Wake channels 0 and 2 both carry phy 7 (0x1, 0x2) → entry captures 0x1.
- `flush=1` with 6 entries and `in_valid`=11 → next cycle `count=0`, `out_valid=0`, no new entries.
- With the macro defined, enqueue rs2=9 unloaded while wake phy 9 = 0x4a5cddef → op issues the following cycle with that value. With the macro undefined, it remains unissued.

Source files
------------

// File: rtl/issue_queue_if.sv
// Issue queue port bundle: enqueue group, wakeup broadcast, issue handshake,
// flush and status. The producer/testbench side uses `master`, the queue
// itself uses `slave`.
interface issue_queue_if #(
    parameter int DEPTH     = 16,
    parameter int IN_WIDTH  = 2,
    parameter int WAKE_NUM  = 4,
    parameter int PHY_W     = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 flush;

    logic [IN_WIDTH-1:0]  in_valid;
    logic [PHY_W-1:0]     in_rs1_phy    [IN_WIDTH];
    logic [PHY_W-1:0]     in_rs2_phy    [IN_WIDTH];
    logic [IN_WIDTH-1:0]  in_src1_loaded;
    logic [IN_WIDTH-1:0]  in_src2_loaded;
    logic [DATA_W-1:0]    in_src1_value [IN_WIDTH];
    logic [DATA_W-1:0]    in_src2_value [IN_WIDTH];
    logic [PAYLOAD_W-1:0] in_payload    [IN_WIDTH];
    logic                 stall;

    logic [WAKE_NUM-1:0]  wake_enable;
    logic [PHY_W-1:0]     wake_phy_id   [WAKE_NUM];
    logic [DATA_W-1:0]    wake_value    [WAKE_NUM];

    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_src1_value;
    logic [DATA_W-1:0]    out_src2_value;
    logic [PAYLOAD_W-1:0] out_payload;

    logic [CNT_W-1:0]     count;

    modport master (
        output flush, in_valid, in_rs1_phy, in_rs2_phy, in_src1_loaded, in_src2_loaded,
               in_src1_value, in_src2_value, in_payload,
               wake_enable, wake_phy_id, wake_value, out_ready,
        input  stall, out_valid, out_src1_value, out_src2_value, out_payload, count
    );

    modport slave (
        input  flush, in_valid, in_rs1_phy, in_rs2_phy, in_src1_loaded, in_src2_loaded,
               in_src1_value, in_src2_value, in_payload,
               wake_enable, wake_phy_id, wake_value, out_ready,
        output stall, out_valid, out_src1_value, out_src2_value, out_payload, count
    );
endinterface

// File: rtl/issue_queue.sv
// Collapsing, age-ordered issue queue. Entry 0 is the oldest; valid entries
// are always contiguous from index 0, so `valid` is derived from `count`.
// Optional feature macro: ISSUE_QUEUE_WAKEUP_BYPASS_EN -- when defined,
// incoming ops also capture same-cycle wakeups before being written.
module issue_queue #(
    parameter int DEPTH     = 16,
    parameter int IN_WIDTH  = 2,
    parameter int WAKE_NUM  = 4,
    parameter int PHY_W     = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                 l1;
        logic                 l2;
        logic [PHY_W-1:0]     rs1;
        logic [PHY_W-1:0]     rs2;
        logic [DATA_W-1:0]    v1;
        logic [DATA_W-1:0]    v2;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t               ent [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [CNT_W-1:0]     count_r;

    entry_t               wk  [DEPTH];
    entry_t               nxt [DEPTH];
    entry_t               inc [IN_WIDTH];
    entry_t               out_e;
    int                   sel_idx;
    int                   cnt_next;
    logic                 issue;
    logic                 enq_ok;

    logic [WAKE_NUM-1:0]              wen;
    logic [WAKE_NUM-1:0][PHY_W-1:0]   wphy;
    logic [WAKE_NUM-1:0][DATA_W-1:0]  wval;

    // Capture wakeups into unloaded sources; channels scanned high to low so
    // the lowest matching channel is the one that sticks.
    function automatic entry_t wake_entry(
        input entry_t                          e,
        input logic [WAKE_NUM-1:0]             en,
        input logic [WAKE_NUM-1:0][PHY_W-1:0]  ph,
        input logic [WAKE_NUM-1:0][DATA_W-1:0] vl
    );
        entry_t r;
        r = e;
        for (int c = WAKE_NUM - 1; c >= 0; c--) begin
            if (en[c] && !e.l1 && ph[c] == e.rs1) begin
                r.l1 = 1'b1;
                r.v1 = vl[c];
            end
            if (en[c] && !e.l2 && ph[c] == e.rs2) begin
                r.l2 = 1'b1;
                r.v2 = vl[c];
            end
        end
        return r;
    endfunction

    // Repack the wake channels into packed vectors for the compare function.
    always_comb begin
        wen = bus.wake_enable;
        for (int c = 0; c < WAKE_NUM; c++) begin
            wphy[c] = bus.wake_phy_id[c];
            wval[c] = bus.wake_value[c];
        end
    end

    // Pick the oldest entry with both sources loaded; idle outputs show entry 0.
    always_comb begin
        sel_idx = DEPTH;
        out_e   = ent[0];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && ent[i].l1 && ent[i].l2) begin
                sel_idx = i;
                out_e   = ent[i];
            end
        end
    end

    assign bus.out_valid      = (sel_idx != DEPTH) && !bus.flush;
    assign bus.out_src1_value = out_e.v1;
    assign bus.out_src2_value = out_e.v2;
    assign bus.out_payload    = out_e.payload;
    assign bus.stall          = (DEPTH - int'(count_r)) < IN_WIDTH;
    assign bus.count          = count_r;
    assign issue              = bus.out_valid && bus.out_ready;
    assign enq_ok             = !bus.stall && !bus.flush;

    // Next entry image: wake held entries, collapse over the issued slot,
    // then pack the valid incoming ops behind the shifted tail.
    always_comb begin
        int base;
        int nenq;
        base = int'(count_r) - (issue ? 1 : 0);
        nenq = 0;
        for (int j = 0; j < DEPTH; j++) begin
            wk[j] = wake_entry(ent[j], wen, wphy, wval);
        end
        for (int j = 0; j < DEPTH; j++) begin
            nxt[j] = wk[j];
            if (issue && j >= sel_idx && j < DEPTH - 1) begin
                nxt[j] = wk[j + 1];
            end
        end
        for (int k = 0; k < IN_WIDTH; k++) begin
            inc[k].l1      = bus.in_src1_loaded[k];
            inc[k].l2      = bus.in_src2_loaded[k];
            inc[k].rs1     = bus.in_rs1_phy[k];
            inc[k].rs2     = bus.in_rs2_phy[k];
            inc[k].v1      = bus.in_src1_value[k];
            inc[k].v2      = bus.in_src2_value[k];
            inc[k].payload = bus.in_payload[k];
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
            inc[k] = wake_entry(inc[k], wen, wphy, wval);
`else
            inc[k] = inc[k];
`endif
            if (enq_ok && bus.in_valid[k]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == base + nenq) begin
                        nxt[j] = inc[k];
                    end
                end
                nenq = nenq + 1;
            end
        end
        cnt_next = bus.flush ? 0 : base + nenq;
    end

    // Entry payload registers carry no reset; their validity comes from count.
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            ent[j] <= nxt[j];
        end
    end

    // Occupancy and valid bits, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            valid   <= '0;
        end else begin
            count_r <= CNT_W'(cnt_next);
            for (int j = 0; j < DEPTH; j++) begin
                valid[j] <= (j < cnt_next);
            end
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: stimulus pushes expected issues, a
// negedge monitor pops and compares every accepted output.
module tb_issue_queue;
    localparam int DEPTH     = 16;
    localparam int IN_WIDTH  = 2;
    localparam int WAKE_NUM  = 4;
    localparam int PHY_W     = 6;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 64;

    typedef struct packed {
        logic [31:0] v1;
        logic [31:0] v2;
        logic [63:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    issue_queue_if #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .WAKE_NUM(WAKE_NUM),
                     .PHY_W(PHY_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    issue_queue #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .WAKE_NUM(WAKE_NUM),
                  .PHY_W(PHY_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic clear_in();
        bus.flush       = 1'b0;
        bus.in_valid    = '0;
        bus.wake_enable = '0;
        bus.in_src1_loaded = '0;
        bus.in_src2_loaded = '0;
        for (int k = 0; k < IN_WIDTH; k++) begin
            bus.in_rs1_phy[k]    = '0;
            bus.in_rs2_phy[k]    = '0;
            bus.in_src1_value[k] = '0;
            bus.in_src2_value[k] = '0;
            bus.in_payload[k]    = '0;
        end
        for (int c = 0; c < WAKE_NUM; c++) begin
            bus.wake_phy_id[c] = '0;
            bus.wake_value[c]  = '0;
        end
    endtask

    task automatic set_op(input int k, input logic [5:0] rs1, input logic l1, input logic [31:0] v1,
                          input logic [5:0] rs2, input logic l2, input logic [31:0] v2,
                          input logic [63:0] p);
        bus.in_valid[k]       = 1'b1;
        bus.in_rs1_phy[k]     = rs1;
        bus.in_src1_loaded[k] = l1;
        bus.in_src1_value[k]  = v1;
        bus.in_rs2_phy[k]     = rs2;
        bus.in_src2_loaded[k] = l2;
        bus.in_src2_value[k]  = v2;
        bus.in_payload[k]     = p;
    endtask

    task automatic set_wake(input int c, input logic [5:0] phy, input logic [31:0] val);
        bus.wake_enable[c] = 1'b1;
        bus.wake_phy_id[c] = phy;
        bus.wake_value[c]  = val;
    endtask

    // Monitor: every accepted issue must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got payload %h expected no issue", bus.out_payload);
                end else begin
                    e = sb.pop_front();
                    chk("issue", {bus.out_src1_value, bus.out_src2_value, bus.out_payload}, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        clear_in();
        step();
        step();
        neg();
        chk("rst_count", 128'(bus.count), 0);
        chk("rst_stall", 128'(bus.stall), 0);
        chk("rst_out_valid", 128'(bus.out_valid), 0);

        // Two ready ops issue back to back in slot order.
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        set_op(0, 6'd1, 1'b1, 32'ha0, 6'd2, 1'b1, 32'hb0, 64'h11);
        set_op(1, 6'd3, 1'b1, 32'ha1, 6'd4, 1'b1, 32'hb1, 64'h22);
        sb.push_back('{32'ha0, 32'hb0, 64'h11});
        sb.push_back('{32'ha1, 32'hb1, 64'h22});
        step();
        clear_in();
        neg();
        chk("t1_count2", 128'(bus.count), 2);
        step();
        neg();
        chk("t1_count1", 128'(bus.count), 1);
        step();
        neg();
        chk("t1_count0", 128'(bus.count), 0);

        // Younger ready op overtakes an older waiting one; wake releases it.
        step();
        set_op(0, 6'd5, 1'b0, 32'h0, 6'd0, 1'b1, 32'h3, 64'hA);
        set_op(1, 6'd6, 1'b1, 32'h10, 6'd0, 1'b1, 32'h20, 64'hB);
        sb.push_back('{32'h10, 32'h20, 64'hB});
        step();
        clear_in();
        set_wake(0, 6'd5, 32'hacde1285);
        sb.push_back('{32'hacde1285, 32'h3, 64'hA});
        step();
        clear_in();
        neg();
        chk("t2_a_ready", 128'(bus.out_valid), 1);
        step();
        neg();
        chk("t2_count0", 128'(bus.count), 0);

        // Issue, shift-while-woken and enqueue in the same cycle.
        step();
        set_op(0, 6'd0, 1'b1, 32'h41, 6'd0, 1'b1, 32'h42, 64'h31);
        set_op(1, 6'd12, 1'b0, 32'h0, 6'd0, 1'b1, 32'h43, 64'h32);
        sb.push_back('{32'h41, 32'h42, 64'h31});
        step();
        clear_in();
        set_wake(1, 6'd12, 32'h5555);
        set_op(0, 6'd0, 1'b1, 32'h51, 6'd0, 1'b1, 32'h52, 64'h33);
        sb.push_back('{32'h5555, 32'h43, 64'h32});
        sb.push_back('{32'h51, 32'h52, 64'h33});
        step();
        clear_in();
        neg();
        chk("t3_count2", 128'(bus.count), 2);
        step();
        step();
        neg();
        chk("t3_count0", 128'(bus.count), 0);

        // Two channels hit the same phy: channel 0 wins.
        step();
        set_op(0, 6'd0, 1'b1, 32'h61, 6'd7, 1'b0, 32'h0, 64'h44);
        step();
        clear_in();
        set_wake(0, 6'd7, 32'h1);
        set_wake(1, 6'd8, 32'h3);
        set_wake(2, 6'd7, 32'h2);
        sb.push_back('{32'h61, 32'h1, 64'h44});
        step();
        clear_in();
        step();
        neg();
        chk("t4_count0", 128'(bus.count), 0);

        // Fill to DEPTH-1 with waiting ops; last single op packed from slot 1.
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_op(0, 6'd20, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 64'(32'h100 + 2 * i));
            set_op(1, 6'd20, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 64'(32'h101 + 2 * i));
            step();
            clear_in();
        end
        set_op(1, 6'd21, 1'b0, 32'h0, 6'd0, 1'b1, 32'h99, 64'h1FF);
        step();
        clear_in();
        neg();
        chk("t5_count15", 128'(bus.count), 15);
        chk("t5_stall", 128'(bus.stall), 1);
        chk("t5_no_ready", 128'(bus.out_valid), 0);
        step();
        set_op(0, 6'd22, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 64'h2F0);
        set_op(1, 6'd22, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 64'h2F1);
        set_wake(0, 6'd21, 32'hbeef);
        sb.push_back('{32'hbeef, 32'h99, 64'h1FF});
        step();
        clear_in();
        neg();
        chk("t5_stalled_count", 128'(bus.count), 15);
        step();
        bus.out_ready = 1'b1;
        set_op(0, 6'd22, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 64'h2F2);
        set_op(1, 6'd22, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 64'h2F3);
        neg();
        chk("t5_stall_during_issue", 128'(bus.stall), 1);
        step();
        clear_in();
        bus.out_ready = 1'b0;
        neg();
        chk("t5_count14", 128'(bus.count), 14);
        chk("t5_unstall", 128'(bus.stall), 0);

        // Flush clears everything; with 6 entries and a full group offered.
        step();
        bus.flush = 1'b1;
        step();
        clear_in();
        neg();
        chk("t6_flush_a", 128'(bus.count), 0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_op(0, 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'h1, 64'(32'h200 + i));
            set_op(1, 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'h2, 64'(32'h210 + i));
            step();
            clear_in();
        end
        neg();
        chk("t6_count6", 128'(bus.count), 6);
        step();
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        set_op(0, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 64'h2A0);
        set_op(1, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 64'h2A1);
        neg();
        chk("t6_flush_out_valid", 128'(bus.out_valid), 0);
        step();
        clear_in();
        neg();
        chk("t6_count0", 128'(bus.count), 0);
        chk("t6_out_valid0", 128'(bus.out_valid), 0);

        // Wake arriving in the enqueue cycle.
        step();
        set_op(0, 6'd0, 1'b1, 32'h71, 6'd9, 1'b0, 32'h0, 64'h77);
        set_wake(3, 6'd9, 32'h4a5cddef);
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
        sb.push_back('{32'h71, 32'h4a5cddef, 64'h77});
`endif
        step();
        clear_in();
        step();
        step();
        neg();
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
        chk("t7_count", 128'(bus.count), 0);
`else
        chk("t7_count", 128'(bus.count), 1);
`endif
        chk("t7_out_valid", 128'(bus.out_valid), 0);

        // Asynchronous reset in mid-cycle empties the queue at once.
        step();
        bus.flush = 1'b1;
        step();
        clear_in();
        bus.out_ready = 1'b0;
        set_op(0, 6'd0, 1'b1, 32'h81, 6'd0, 1'b1, 32'h82, 64'h88);
        set_op(1, 6'd0, 1'b1, 32'h83, 6'd0, 1'b1, 32'h84, 64'h89);
        step();
        clear_in();
        neg();
        chk("t8_count2", 128'(bus.count), 2);
        chk("t8_ready", 128'(bus.out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t8_async_count", 128'(bus.count), 0);
        chk("t8_async_out_valid", 128'(bus.out_valid), 0);
        chk("t8_async_stall", 128'(bus.stall), 0);
        step();
        rst = 1'b0;
        step();
        neg();
        chk("sb_empty", 128'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
